// File: rtl/qeip_sram_loader_pkg.sv
// Shared types and constants for the QEIP SRAM loader (AXI write master).
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package qeip_sram_loader_pkg;

  // Transfer sequencer states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [2:0]  AXI_SIZE_4B    = 3'd2;
  localparam logic [1:0]  AXI_BURST_INCR = 2'd1;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'd0;
  localparam logic [3:0]  AXI_WSTRB_ALL  = 4'hF;

  // Byte offset within a 4 KB page; AXI bursts may not cross this boundary
  localparam logic [11:0] PAGE_MASK      = 12'hFFF;

  // Reverse byte order of a 32-bit word (big-endian source stream)
  function automatic logic [31:0] byteswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/qeip_sram_loader_if.sv
// AXI write-only channel bundle (AW/W/B) between the loader and the SRAM slave.
// Latency: n/a (wires only).
// Backpressure: standard AXI valid/ready on each channel.
interface qeip_sram_loader_if #(
  parameter int BW_ADDR    = 32,
  parameter int BW_AXI_TID = 4
);

  logic [BW_AXI_TID-1:0] txawid;
  logic [BW_ADDR-1:0]    txawaddr;
  logic [3:0]            txawlen;
  logic [2:0]            txawsize;
  logic [1:0]            txawburst;
  logic                  txawvalid;
  logic                  txawready;

  logic [BW_AXI_TID-1:0] txwid;
  logic [31:0]           txwdata;
  logic [3:0]            txwstrb;
  logic                  txwlast;
  logic                  txwvalid;
  logic                  txwready;

  logic [1:0]            txbresp;
  logic                  txbvalid;
  logic                  txbready;

  modport master (
    output txawid, txawaddr, txawlen, txawsize, txawburst, txawvalid,
    input  txawready,
    output txwid, txwdata, txwstrb, txwlast, txwvalid,
    input  txwready,
    input  txbresp, txbvalid,
    output txbready
  );

  modport slave (
    input  txawid, txawaddr, txawlen, txawsize, txawburst, txawvalid,
    output txawready,
    input  txwid, txwdata, txwstrb, txwlast, txwvalid,
    output txwready,
    output txbresp, txbvalid,
    input  txbready
  );

endinterface

// File: rtl/qeip_sram_loader_burst_calc.sv
// Burst sizing: beats = min(remaining words, MAX_BURST, words left in the 4 KB page).
// Latency: purely combinational.
// Backpressure: none; result is registered by the caller on entry to AW.
module qeip_sram_loader_burst_calc
  import qeip_sram_loader_pkg::*;
#(
  parameter int MAX_BURST = 16
) (
  input  logic [11:0] page_off_i,
  input  logic [15:0] rem_i,
  output logic [4:0]  beats_o
);

  logic [12:0] page_bytes;
  logic [15:0] page_words;
  logic [15:0] beats_w;
  logic        unused_bits;

  // Bytes left before the next 4 KB boundary: 4..4096, so 1..1024 words
  assign page_bytes = 13'd4096 - {1'b0, page_off_i & PAGE_MASK};
  assign page_words = {5'b0, page_bytes[12:2]};

  // Three-way minimum; result never exceeds MAX_BURST, so 5 bits suffice
  always_comb begin
    beats_w = rem_i;
    if (beats_w > 16'(MAX_BURST)) beats_w = 16'(MAX_BURST);
    if (beats_w > page_words)     beats_w = page_words;
  end

  assign beats_o     = beats_w[4:0];
  assign unused_bits = |{beats_w[15:5], page_bytes[1:0]};

endmodule

// File: rtl/qeip_sram_loader.sv
// AXI write master filling QEIP SRAM from a 32-bit word stream in 4 KB-safe INCR bursts.
// Latency: one AW per burst, W beats pass combinationally from the stream, one burst outstanding.
// Backpressure: sxready follows txwready in W only; stream gaps and W stalls stretch the burst.
// Optional QEIP_SRAM_LOADER_BYTESWAP_EN: byte-reverse each stream word onto txwdata.
module qeip_sram_loader
  import qeip_sram_loader_pkg::*;
#(
  parameter int BW_ADDR    = 32,
  parameter int BW_AXI_TID = 4,
  parameter int MAX_BURST  = 16
) (
  input  logic               clk,
  input  logic               rstnn,
  input  logic               start,
  input  logic [BW_ADDR-1:0] cfg_addr,
  input  logic [15:0]        cfg_len,
  output logic               busy,
  output logic               done,
  output logic               err,
  input  logic               sxvalid,
  input  logic [31:0]        sxdata,
  output logic               sxready,
  qeip_sram_loader_if.master axi
);

  localparam logic [BW_AXI_TID-1:0] AXI_ID = '0;

  state_e               state_q, state_d;
  logic [BW_ADDR-1:0]   addr_q,  addr_d;
  logic [15:0]          rem_q,   rem_d;
  logic [4:0]           beats_q, beats_d;
  logic [3:0]           cnt_q,   cnt_d;
  logic                 err_q,   err_d;
  logic                 load_beats;
  logic [4:0]           calc_beats;
  logic [15:0]          rem_next;
  logic                 in_w;
  logic                 last_beat;
  logic                 w_fire;
  logic [31:0]          wdata_src;
  logic                 unused_cfg_bits;

  assign in_w      = (state_q == ST_W);
  assign last_beat = ({1'b0, cnt_q} == (beats_q - 5'd1));
  assign w_fire    = in_w && sxvalid && axi.txwready;
  assign rem_next  = rem_q - {11'b0, beats_q};

  // Sizes the next burst from the address/remaining count it will start with
  qeip_sram_loader_burst_calc #(
    .MAX_BURST (MAX_BURST)
  ) u_burst_calc (
    .page_off_i (addr_d[11:0]),
    .rem_i      (rem_d),
    .beats_o    (calc_beats)
  );

  // Burst size is captured on AW entry and held for the whole burst
  assign beats_d = load_beats ? calc_beats : beats_q;

  // Next-state and datapath updates for the transfer sequencer
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    load_beats = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d = {cfg_addr[BW_ADDR-1:2], 2'b00};
          rem_d  = cfg_len;
          err_d  = 1'b0;
          cnt_d  = '0;
          if (cfg_len == 16'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_AW;
            load_beats = 1'b1;
          end
        end
      end
      ST_AW: begin
        if (axi.txawready) state_d = ST_W;
      end
      ST_W: begin
        if (w_fire) begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = ST_B;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      ST_B: begin
        if (axi.txbvalid) begin
          if (axi.txbresp != AXI_RESP_OKAY) err_d = 1'b1;
          rem_d  = rem_next;
          addr_d = addr_q + BW_ADDR'({beats_q, 2'b00});
          if (rem_next == 16'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_AW;
            load_beats = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any burst in flight
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      beats_q <= 5'd1;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      beats_q <= beats_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifdef QEIP_SRAM_LOADER_BYTESWAP_EN
  assign wdata_src = byteswap32(sxdata);
`else
  assign wdata_src = sxdata;
`endif

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign err     = err_q;
  assign sxready = in_w && axi.txwready;

  assign axi.txawid    = AXI_ID;
  assign axi.txawaddr  = addr_q;
  assign axi.txawlen   = 4'(beats_q - 5'd1);
  assign axi.txawsize  = AXI_SIZE_4B;
  assign axi.txawburst = AXI_BURST_INCR;
  assign axi.txawvalid = (state_q == ST_AW);

  assign axi.txwid     = AXI_ID;
  assign axi.txwdata   = in_w ? wdata_src : 32'd0;
  assign axi.txwstrb   = AXI_WSTRB_ALL;
  assign axi.txwlast   = in_w && last_beat;
  assign axi.txwvalid  = in_w && sxvalid;

  assign axi.txbready  = (state_q == ST_B);

  assign unused_cfg_bits = ^cfg_addr[1:0];

endmodule

// File: tb/tb_qeip_sram_loader.sv
// Randomized bench for qeip_sram_loader: AXI SRAM slave model plus burst/memory reference model.
// Latency: inputs driven on the falling edge, handshakes observed 1 time unit later.
// Backpressure: randomized sxvalid gaps, txawready/txwready stalls and delayed txbvalid.
module tb_qeip_sram_loader;

  localparam int BW_ADDR    = 32;
  localparam int BW_AXI_TID = 4;
  localparam int MAX_BURST  = 16;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  len;
  } aw_t;

  logic        clk = 1'b0;
  logic        rstnn;
  logic        start;
  logic [31:0] cfg_addr;
  logic [15:0] cfg_len;
  logic        busy, done, err;
  logic        sxvalid;
  logic [31:0] sxdata;
  logic        sxready;

  always #5 clk = ~clk;

  qeip_sram_loader_if #(.BW_ADDR(BW_ADDR), .BW_AXI_TID(BW_AXI_TID)) axi ();

  qeip_sram_loader #(
    .BW_ADDR    (BW_ADDR),
    .BW_AXI_TID (BW_AXI_TID),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .clk      (clk),
    .rstnn    (rstnn),
    .start    (start),
    .cfg_addr (cfg_addr),
    .cfg_len  (cfg_len),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .sxvalid  (sxvalid),
    .sxdata   (sxdata),
    .sxready  (sxready),
    .axi      (axi)
  );

  int n_checks = 0;
  int n_errors = 0;

  aw_t         exp_aw[$];
  aw_t         obs_aw[$];
  aw_t         slv_q[$];
  logic [31:0] exp_words[$];
  logic [31:0] src_q[$];
  logic [31:0] mem[logic [31:0]];

  int   slv_beat, b_pending, b_idx, err_burst, done_cnt;
  int   dup_cnt, w_early, wlast_err, data_err, hs_err, beats_seen;
  int   valid_pct, ready_pct;
  logic bvalid_hold;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_wdata(input logic [31:0] d);
`ifdef QEIP_SRAM_LOADER_BYTESWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  // One clock: drive stimulus and slave responses, then record what the next edge accepts
  task automatic step(input logic st);
    logic [31:0] a;
    aw_t         rec;
    @(negedge clk);
    start   = st;
    sxvalid = (src_q.size() > 0) && ($urandom_range(1, 100) <= valid_pct);
    sxdata  = (src_q.size() > 0) ? src_q[0] : $urandom;
    axi.txawready = ($urandom_range(1, 100) <= ready_pct);
    axi.txwready  = ($urandom_range(1, 100) <= ready_pct);
    if (!bvalid_hold && b_pending > 0 && $urandom_range(0, 1) == 1) bvalid_hold = 1'b1;
    axi.txbvalid = bvalid_hold;
    axi.txbresp  = (bvalid_hold && b_idx == err_burst) ? 2'd2 : 2'd0;
    #1;
    if (done) done_cnt++;
    if (axi.txawvalid && axi.txawready) begin
      rec.addr = axi.txawaddr;
      rec.len  = axi.txawlen;
      obs_aw.push_back(rec);
      slv_q.push_back(rec);
    end
    if ((sxvalid && sxready) != (axi.txwvalid && axi.txwready)) hs_err++;
    if (axi.txwvalid && axi.txwready) begin
      beats_seen++;
      if (axi.txwdata != exp_wdata(sxdata)) data_err++;
      if (slv_q.size() == 0) begin
        w_early++;
      end else begin
        a = slv_q[0].addr + 32'(slv_beat * 4);
        if (mem.exists(a)) dup_cnt++;
        mem[a] = axi.txwdata;
        if (axi.txwlast != (slv_beat == int'(slv_q[0].len))) wlast_err++;
        if (slv_beat == int'(slv_q[0].len)) begin
          void'(slv_q.pop_front());
          slv_beat = 0;
          b_pending++;
        end else begin
          slv_beat++;
        end
      end
    end
    if (sxvalid && sxready) void'(src_q.pop_front());
    if (axi.txbvalid && axi.txbready) begin
      b_pending--;
      b_idx++;
      bvalid_hold = 1'b0;
    end
  endtask

  // Reference model: burst list from min(rem, MAX_BURST, page words), words in stream order
  task automatic setup_xfer(input logic [31:0] addr, input int len, input int vpct,
                            input int rpct, input int ebur, input bit seq_data);
    aw_t         e;
    logic [31:0] a;
    int          r, b, pg;
    exp_aw.delete();
    a = addr & 32'hFFFF_FFFC;
    r = len;
    while (r > 0) begin
      b  = (r > MAX_BURST) ? MAX_BURST : r;
      pg = (4096 - int'(a % 32'd4096)) / 4;
      if (b > pg) b = pg;
      e.addr = a;
      e.len  = 4'(b - 1);
      exp_aw.push_back(e);
      r -= b;
      a += 32'(4 * b);
    end
    exp_words.delete();
    for (int i = 0; i < len; i++) exp_words.push_back(seq_data ? 32'(i + 1) : $urandom);
    src_q = exp_words;
    obs_aw.delete();
    slv_q.delete();
    mem.delete();
    slv_beat = 0; b_pending = 0; b_idx = 0; done_cnt = 0;
    dup_cnt = 0; w_early = 0; wlast_err = 0; data_err = 0; hs_err = 0; beats_seen = 0;
    bvalid_hold = 1'b0;
    valid_pct = vpct;
    ready_pct = rpct;
    err_burst = ebur;
    cfg_addr  = addr;
    cfg_len   = 16'(len);
  endtask

  task automatic run_xfer(input string name, input logic [31:0] addr, input int len,
                          input int vpct, input int rpct, input int ebur,
                          input bit seq_data, input bit stray);
    int          cyc, mem_err;
    logic        st, busy_first, err_first;
    logic [31:0] a;
    setup_xfer(addr, len, vpct, rpct, ebur, seq_data);
    step(1'b1);
    cyc = 0; busy_first = 1'b0; err_first = 1'b1;
    while (done_cnt == 0 && cyc < 3000) begin
      st = 1'b0;
      if (stray && (cyc == 3 || cyc == 9)) begin
        cfg_addr = 32'h0000_0800;
        cfg_len  = 16'd3;
        st       = 1'b1;
      end
      step(st);
      if (cyc == 0) begin
        busy_first = busy;
        err_first  = err;
      end
      cyc++;
    end
    chk({name, "_done_seen"}, 64'(done_cnt), 64'(1));
    chk({name, "_busy_after_start"}, 64'(busy_first), 64'(1));
    chk({name, "_err_clr_on_start"}, 64'(err_first), 64'(0));
    chk({name, "_err_at_done"}, 64'(err), 64'((ebur >= 0 && ebur < exp_aw.size()) ? 1 : 0));
    if (len == 0) chk({name, "_zero_len_latency_ok"}, 64'((cyc >= 1 && cyc <= 2) ? 1 : 0), 64'(1));
    step(1'b0);
    chk({name, "_busy_low_after_done"}, 64'(busy), 64'(0));
    chk({name, "_done_low_after_done"}, 64'(done), 64'(0));
    step(1'b0);
    chk({name, "_done_once"}, 64'(done_cnt), 64'(1));
    chk({name, "_aw_count"}, 64'(obs_aw.size()), 64'(exp_aw.size()));
    for (int i = 0; i < exp_aw.size() && i < obs_aw.size(); i++) begin
      chk($sformatf("%s_aw%0d_addr", name, i), 64'(obs_aw[i].addr), 64'(exp_aw[i].addr));
      chk($sformatf("%s_aw%0d_len", name, i), 64'(obs_aw[i].len), 64'(exp_aw[i].len));
    end
    chk({name, "_beats"}, 64'(beats_seen), 64'(len));
    chk({name, "_dup_writes"}, 64'(dup_cnt), 64'(0));
    chk({name, "_w_before_aw"}, 64'(w_early), 64'(0));
    chk({name, "_wlast_errs"}, 64'(wlast_err), 64'(0));
    chk({name, "_wdata_errs"}, 64'(data_err), 64'(0));
    chk({name, "_stream_hs_errs"}, 64'(hs_err), 64'(0));
    chk({name, "_b_outstanding"}, 64'(b_pending), 64'(0));
    mem_err = 0;
    for (int i = 0; i < len; i++) begin
      a = (addr & 32'hFFFF_FFFC) + 32'(4 * i);
      if (!mem.exists(a)) mem_err++;
      else if (mem[a] != exp_wdata(exp_words[i])) mem_err++;
    end
    chk({name, "_mem_mismatches"}, 64'(mem_err), 64'(0));
  endtask

  initial begin
    rstnn = 1'b0; start = 1'b0; cfg_addr = '0; cfg_len = '0;
    sxvalid = 1'b0; sxdata = '0;
    axi.txawready = 1'b0; axi.txwready = 1'b0; axi.txbvalid = 1'b0; axi.txbresp = 2'd0;
    bvalid_hold = 1'b0; valid_pct = 0; ready_pct = 0; err_burst = -1;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy",      64'(busy),          64'(0));
    chk("rst_done",      64'(done),          64'(0));
    chk("rst_err",       64'(err),           64'(0));
    chk("rst_sxready",   64'(sxready),       64'(0));
    chk("rst_awvalid",   64'(axi.txawvalid), 64'(0));
    chk("rst_awaddr",    64'(axi.txawaddr),  64'(0));
    chk("rst_awlen",     64'(axi.txawlen),   64'(0));
    chk("rst_awid",      64'(axi.txawid),    64'(0));
    chk("rst_awsize",    64'(axi.txawsize),  64'(2));
    chk("rst_awburst",   64'(axi.txawburst), 64'(1));
    chk("rst_wstrb",     64'(axi.txwstrb),   64'(4'hF));
    chk("rst_wvalid_wlast_wdata", 64'({axi.txwvalid, axi.txwlast, axi.txwdata}), 64'(0));
    chk("rst_bready",    64'(axi.txbready),  64'(0));
    @(negedge clk);
    rstnn = 1'b1;

    run_xfer("t1_single",   32'h0000_0100, 5,  100, 100, -1, 1'b1, 1'b0);
    run_xfer("t2_three",    32'h0000_0000, 40, 80,  80,  -1, 1'b0, 1'b0);
    run_xfer("t3_page",     32'h0000_0FF8, 4,  90,  70,  -1, 1'b0, 1'b0);
    run_xfer("t4_bresp",    32'h0000_0203, 20, 90,  90,  1,  1'b0, 1'b0);
    run_xfer("t5_stall",    32'h0000_3000, 33, 60,  50,  -1, 1'b0, 1'b1);
    run_xfer("t6_zero",     32'h0000_0040, 0,  100, 100, -1, 1'b0, 1'b0);

    // Reset in the middle of a transfer, then reset the slave model too
    setup_xfer(32'h0000_0500, 30, 100, 100, -1, 1'b0);
    step(1'b1);
    repeat (8) step(1'b0);
    @(negedge clk);
    rstnn = 1'b0;
    #1;
    chk("midrst_busy",    64'(busy),          64'(0));
    chk("midrst_awvalid", 64'(axi.txawvalid), 64'(0));
    chk("midrst_wvalid",  64'(axi.txwvalid),  64'(0));
    chk("midrst_sxready", 64'(sxready),       64'(0));
    chk("midrst_bready",  64'(axi.txbready),  64'(0));
    src_q.delete(); slv_q.delete(); bvalid_hold = 1'b0; b_pending = 0;
    sxvalid = 1'b0; axi.txawready = 1'b0; axi.txwready = 1'b0; axi.txbvalid = 1'b0;
    repeat (2) @(negedge clk);
    rstnn = 1'b1;

    run_xfer("t7_addr_wrap", 32'hFFFF_FFF0, 8, 75, 75, -1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
